// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the memory-stage data responder: FSM state
// encodings, wait-counter width and an alignment helper.
package dmem_responder_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_sram_1rw.sv
// Single-port synchronous data RAM: write-enable, registered read with a
// read-enable so the output holds its last loaded word between reads.
module sram_1rw #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [1 << DEPTH_LOG2];

  // Array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read port, cleared by reset, updated only on enabled reads.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the M-stage load/store interface. Accepts aligned requests,
// holds the pipeline with stallM for LATENCY+1 cycles, then completes the
// access in DONE (load data valid, store written at the end of DONE).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        alignerrM
);

  if (LATENCY > 15) begin : g_latency_range
    $error("dmem_responder: LATENCY must be 0..15");
  end

  localparam logic [LAT_W-1:0] LAT = LATENCY[LAT_W-1:0];

  state_t                state, state_next;
  logic [LAT_W-1:0]      count;
  logic [DEPTH_LOG2-1:0] idx_in, idx_q, ram_addr;
  logic [31:0]           wdata_q;
  logic                  rd_q, wr_q;
  logic                  req, aligned, accept;
  logic                  ram_we, ram_re;
  logic                  unused_addr_bits;

  assign req              = memreadM | memwriteM;
  assign aligned          = is_aligned(addrM[1:0]);
  assign idx_in           = addrM[DEPTH_LOG2+1:2];
  assign accept           = (state == IDLE) && req && aligned;
  assign unused_addr_bits = ^addrM[31:DEPTH_LOG2+2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // count is loaded with LATENCY-1 so the LATENCY WAIT cycles end on count==0;
  // LATENCY=0 goes straight to DONE so the stall stays LATENCY+1 cycles long.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (LAT == '0) ? DONE : WAIT;
      WAIT: if (count == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait counter and request latch captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      count   <= LAT - 4'd1;
      idx_q   <= idx_in;
      wdata_q <= writedataM;
      rd_q    <= memreadM;
      wr_q    <= memwriteM;
    end else if (state == WAIT && count != '0) begin
      count <= count - 4'd1;
    end
  end

  // Outputs and RAM control.
  // The read is issued on the edge entering DONE, the write on the edge
  // leaving it, so a read+write request returns the pre-write word.
  always_comb begin
    stallM    = accept || (state == WAIT);
    alignerrM = (state == IDLE) && req && !aligned;
    ram_addr  = (state == IDLE) ? idx_in : idx_q;
    ram_re    = (state_next == DONE) && ((state == IDLE) ? memreadM : rd_q);
    ram_we    = (state == DONE) && wr_q && !rst;
  end

  sram_1rw #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(readdataM)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table and corner sequences on a
// LATENCY=2 and a LATENCY=0 instance, then random traffic against a word-array
// reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, a_aerr, b_stall, b_aerr;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .memreadM(a_rd), .memwriteM(a_wr), .addrM(a_addr),
    .writedataM(a_wdata), .readdataM(a_rdata), .stallM(a_stall), .alignerrM(a_aerr)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .memreadM(b_rd), .memwriteM(b_wr), .addrM(b_addr),
    .writedataM(b_wdata), .readdataM(b_rdata), .stallM(b_stall), .alignerrM(b_aerr)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stalls;
    logic        exp_aerr;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] mdl[1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Runs one request on instance sel (0: LATENCY=2, 1: LATENCY=0), starting
  // just after a rising edge; reports stall cycles, DONE-cycle data and any
  // alignment-error pulse. Ends just after the edge that closes the access.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata,
                        output logic aerr);
    logic s, e;
    bit   fin;
    int   i;
    if (sel) begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; end
    else     begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; end
    stalls = 0; aerr = 1'b0; rdata = '0; fin = 1'b0; i = 0;
    while (!fin && i < 40) begin
      @(negedge clk);
      s = sel ? b_stall : a_stall;
      e = sel ? b_aerr  : a_aerr;
      aerr = aerr | e;
      if (!s) begin
        rdata = sel ? b_rdata : a_rdata;
        fin = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
      i++;
    end
    check("stall_timeout", {31'd0, fin}, 32'd1);
    @(posedge clk); #1;
    if (sel) begin b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0; end
    else     begin a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0; end
  endtask

  initial begin
    int          st;
    logic [31:0] rdv;
    logic        ae;
    logic [31:0] last;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 3, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 3, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         32'hDEAD_BEEF, 0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_1234, 32'hDEAD_BEEF, 3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_1234, 3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_000A, 32'h0000_1234, 3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_000B, 32'h0000_000A, 3, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_000B, 3, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0077, 32'hDEAD_BEEF, 3, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0042, 32'h0000_0099, 32'hDEAD_BEEF, 0, 1'b1};

    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall",  {31'd0, a_stall}, 32'd0);
    check("reset_aerr",   {31'd0, a_aerr},  32'd0);
    check("reset_rdata",  a_rdata, 32'd0);
    check("reset_rdata0", b_rdata, 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
      access(1'b0, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, st, rdv, ae);
      check($sformatf("vec%0d_stalls", v), st, vecs[v].exp_stalls);
      check($sformatf("vec%0d_rdata", v), rdv, vecs[v].exp_rd);
      check($sformatf("vec%0d_aerr", v), {31'd0, ae}, {31'd0, vecs[v].exp_aerr});
    end

    // Reset in the second WAIT cycle of a store drops the store.
    a_wr = 1'b1; a_addr = 32'h8; a_wdata = 32'h55;
    @(negedge clk);
    check("rst_seq_accept_stall", {31'd0, a_stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_seq_wait2_stall", {31'd0, a_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    @(negedge clk);
    check("rst_seq_idle_stall", {31'd0, a_stall}, 32'd0);
    check("rst_seq_rdata_clr", a_rdata, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, st, rdv, ae);
    check("rst_seq_load_stalls", st, 3);
    check("rst_seq_load_rdata", rdv, 32'h77);

    // LATENCY=0 instance: single-cycle stall per access.
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0005, st, rdv, ae);
    check("lat0_store_stalls", st, 1);
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, st, rdv, ae);
    check("lat0_load_stalls", st, 1);
    check("lat0_load_rdata", rdv, 32'h5);
    access(1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0006, st, rdv, ae);
    check("lat0_rw_rdata", rdv, 32'h5);
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, st, rdv, ae);
    check("lat0_load2_rdata", rdv, 32'h6);

    // Random traffic on the LATENCY=2 instance over 16 words, with random
    // upper address bits (index wraps modulo 1024) and misaligned requests.
    last = 32'h77;
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      access(1'b0, 1'b0, 1'b1, (($urandom & 32'hFFFF_F000) | (w * 4)), mdl[w], st, rdv, ae);
      check("rand_init_stalls", st, 3);
    end
    for (int n = 0; n < 200; n++) begin
      int unsigned kind, w, idx, exp_st;
      logic        rd, wr, mis, exp_ae;
      logic [31:0] addr, wd, exp_rd;
      kind = $urandom_range(0, 3);
      w    = $urandom_range(0, 15);
      wd   = $urandom;
      addr = ($urandom & 32'hFFFF_F000) | (w * 4);
      mis  = (kind == 3);
      rd   = (kind == 0) || (kind == 2);
      wr   = (kind == 1) || (kind == 2);
      if (mis) begin
        addr = addr | $urandom_range(1, 3);
        rd   = $urandom_range(0, 1) != 0;
        wr   = !rd || ($urandom_range(0, 1) != 0);
      end
      idx = (addr / 4) % 1024;
      if (mis) begin
        exp_st = 0; exp_ae = 1'b1; exp_rd = last;
      end else begin
        exp_st = 3; exp_ae = 1'b0;
        if (rd) last = mdl[idx];
        exp_rd = last;
        if (wr) mdl[idx] = wd;
      end
      access(1'b0, rd, wr, addr, wd, st, rdv, ae);
      check($sformatf("rand%0d_stalls", n), st, exp_st);
      check($sformatf("rand%0d_rdata", n), rdv, exp_rd);
      check($sformatf("rand%0d_aerr", n), {31'd0, ae}, {31'd0, exp_ae});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
